// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between NUM_CH byte-stream
// requesters using round-robin arbitration. A grant captures the winning
// byte, pulses tx_start, then times the frame plus an idle gap on s_tick.
// Optional packet locking is compiled in with the macro UART_ARB_LOCK_EN.
module uart_tx_arbiter #(
    parameter int NUM_CH    = 4,
    parameter int BITWIDTH  = 8,
    parameter int SB_TICK   = 16,
    parameter int GAP_TICKS = 16,
    localparam int GW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       s_tick,
    input  logic [NUM_CH-1:0]          req_valid,
    input  logic [NUM_CH*BITWIDTH-1:0] req_data,
    output logic [NUM_CH-1:0]          req_ready,
    output logic                       tx_start,
    output logic [BITWIDTH-1:0]        tx_din,
    output logic                       busy,
    output logic [GW-1:0]              grant_id,
    output logic                       frame_done
`ifdef UART_ARB_LOCK_EN
    ,
    input  logic [NUM_CH-1:0]          req_lock
`endif
);

    localparam int FRAME_TICKS = SB_TICK * (BITWIDTH + 2);
    localparam int TOTAL       = FRAME_TICKS + GAP_TICKS;
    localparam int CW          = $clog2(TOTAL + 1);
    localparam logic [CW-1:0] LAST_TICK = CW'(TOTAL - 1);
    localparam logic [GW-1:0] PTR_INIT  = GW'(NUM_CH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [CW-1:0]       tick_cnt;
    logic [CW-1:0]       tick_cnt_next;
    logic [GW-1:0]       ptr;
    logic [GW-1:0]       rr_idx;
    logic [GW-1:0]       rr_winner;
    logic                rr_found;
    logic [GW-1:0]       winner;
    logic [BITWIDTH-1:0] win_data;
    logic                grant;
    logic                frame_done_next;

    // Round-robin search: first valid channel strictly after the pointer, wrapping
    always_comb begin
        rr_found  = 1'b0;
        rr_winner = ptr;
        rr_idx    = ptr;
        for (int k = 1; k <= NUM_CH; k++) begin
            rr_idx = GW'((int'(ptr) + k) % NUM_CH);
            if (!rr_found && req_valid[rr_idx]) begin
                rr_found  = 1'b1;
                rr_winner = rr_idx;
            end
        end
    end

`ifdef UART_ARB_LOCK_EN
    logic [7:0] lock_run;
    logic       lock_hit;

    // A locked channel still requesting right after its frame keeps the
    // transmitter, unless it has already been re-granted 255 times in a row
    always_comb begin
        lock_hit = frame_done && req_lock[grant_id] && req_valid[grant_id]
                   && (lock_run != 8'hFF);
        winner   = lock_hit ? grant_id : rr_winner;
        win_data = req_data[winner*BITWIDTH +: BITWIDTH];
    end

    // Length of the current run of lock re-grants; any normal grant restarts it
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_run <= 8'd0;
        end else if (grant) begin
            lock_run <= lock_hit ? lock_run + 8'd1 : 8'd0;
        end
    end
`else
    // Pure round-robin: the search result is the winner
    always_comb begin
        winner   = rr_winner;
        win_data = req_data[winner*BITWIDTH +: BITWIDTH];
    end
`endif

    // Next-state, tick counting and the one-cycle handshake outputs
    always_comb begin
        state_next      = state;
        tick_cnt_next   = tick_cnt;
        frame_done_next = 1'b0;
        grant           = 1'b0;
        tx_start        = 1'b0;
        req_ready       = '0;
        busy            = (state != IDLE);
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    grant         = 1'b1;
                    tick_cnt_next = '0;
                    state_next    = START;
                end
            end
            START: begin
                tx_start            = 1'b1;
                req_ready[grant_id] = 1'b1;
                state_next          = WAIT;
            end
            WAIT: begin
                if (s_tick) begin
                    if (tick_cnt == LAST_TICK) begin
                        frame_done_next = 1'b1;
                        tick_cnt_next   = '0;
                        state_next      = IDLE;
                    end else begin
                        tick_cnt_next = tick_cnt + CW'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, counter, captured byte and arbitration pointer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            frame_done <= 1'b0;
            tx_din     <= '0;
            grant_id   <= '0;
            ptr        <= PTR_INIT;
        end else begin
            state      <= state_next;
            tick_cnt   <= tick_cnt_next;
            frame_done <= frame_done_next;
            if (grant) begin
                tx_din   <= win_data;
                grant_id <= winner;
                ptr      <= winner;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for uart_tx_arbiter. Requesters feed
// bytes from per-channel source queues; presented bytes go to per-channel
// expected queues; a negedge monitor predicts grants and frame timing from
// a free/ticks-remaining model and compares against the DUT outputs.
module tb_uart_tx_arbiter;

    localparam int NUM_CH = 4;
    localparam int BW     = 8;
    localparam int SBT    = 16;
    localparam int GAP    = 16;
    localparam int TOTAL  = SBT * (BW + 2) + GAP;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   s_tick;
    logic [NUM_CH-1:0]      req_valid;
    logic [NUM_CH*BW-1:0]   req_data;
    logic [NUM_CH-1:0]      req_ready;
    logic                   tx_start;
    logic [BW-1:0]          tx_din;
    logic                   busy;
    logic [1:0]             grant_id;
    logic                   frame_done;

    int checks = 0;
    int errors = 0;

    bit mon_en      = 1'b0;
    bit tick_every  = 1'b1;
    int present_pct = 100;

    logic [7:0]        src_q [NUM_CH][$];
    logic [7:0]        exp_q [NUM_CH][$];
    logic [NUM_CH-1:0] ready_seen = '0;

    bit                m_free    = 1'b1;
    bit                m_skip    = 1'b0;
    bit                m_found;
    int                m_left    = 0;
    int                m_ptr     = NUM_CH - 1;
    int                m_gid     = 0;
    int                m_c;
    logic [7:0]        m_din     = 8'h00;
    bit                exp_start = 1'b0;
    bit                exp_done  = 1'b0;
    bit                exp_busy  = 1'b0;
    logic [NUM_CH-1:0] exp_rdy;

    uart_tx_arbiter #(
        .NUM_CH(NUM_CH),
        .BITWIDTH(BW),
        .SB_TICK(SBT),
        .GAP_TICKS(GAP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .s_tick(s_tick),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_ready(req_ready),
        .tx_start(tx_start),
        .tx_din(tx_din),
        .busy(busy),
        .grant_id(grant_id),
        .frame_done(frame_done)
`ifdef UART_ARB_LOCK_EN
        ,
        .req_lock({NUM_CH{1'b0}})
`endif
    );

    // Free-running clock
    always #5 clk = ~clk;

    // One comparison; reports a FAIL line on mismatch
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Requesters remember the acknowledge of the cycle that just ended
    always @(negedge clk) ready_seen = req_ready;

    // One clock of stimulus: reset level, baud strobe and requester behaviour
    task automatic applyStimulus(input logic rst);
        @(posedge clk);
        #1;
        reset  = rst;
        s_tick = tick_every ? 1'b1 : ($urandom_range(9) < 6);
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (ready_seen[ch]) req_valid[ch] = 1'b0;
            if (!req_valid[ch] && src_q[ch].size() > 0 && $urandom_range(99) < present_pct) begin
                req_data[ch*BW +: BW] = src_q[ch].pop_front();
                req_valid[ch]         = 1'b1;
                exp_q[ch].push_back(req_data[ch*BW +: BW]);
            end
        end
    endtask

    function automatic bit pendingWork();
        bit any = (req_valid != '0);
        for (int ch = 0; ch < NUM_CH; ch++) if (src_q[ch].size() > 0) any = 1'b1;
        return any;
    endfunction

    // Run until every queued byte has been sent and the transmitter is free
    task automatic runIdle(input int max_cycles);
        int n = 0;
        while ((pendingWork() || !m_free) && n < max_cycles) begin
            applyStimulus(1'b0);
            n++;
        end
        checks++;
        if (n >= max_cycles) begin
            errors++;
            $display("[TB] FAIL drain_timeout: ran %0d cycles, limit %0d", n, max_cycles);
        end
        repeat (3) applyStimulus(1'b0);
    endtask

    // Monitor: compare this cycle against the prediction, then advance the model
    always @(negedge clk) begin
        if (mon_en) begin
            checkOutput("tx_start", 32'(tx_start), 32'(exp_start));
            checkOutput("frame_done", 32'(frame_done), 32'(exp_done));
            checkOutput("busy", 32'(busy), 32'(exp_busy));
            if (exp_start) begin
                exp_rdy        = '0;
                exp_rdy[m_gid] = 1'b1;
                checkOutput("req_ready_grant", 32'(req_ready), 32'(exp_rdy));
                if (exp_q[m_gid].size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL scoreboard_empty: grant to ch%0d, expected a queued byte", m_gid);
                end else begin
                    m_din = exp_q[m_gid].pop_front();
                end
                checkOutput("tx_din_start", 32'(tx_din), 32'(m_din));
            end else begin
                checkOutput("req_ready_quiet", 32'(req_ready), 32'd0);
                checkOutput("tx_din_hold", 32'(tx_din), 32'(m_din));
            end
            checkOutput("grant_id", 32'(grant_id), 32'(m_gid));
        end
        exp_start = 1'b0;
        exp_done  = 1'b0;
        if (reset) begin
            m_free = 1'b1;
            m_skip = 1'b0;
            m_ptr  = NUM_CH - 1;
            m_gid  = 0;
            m_din  = 8'h00;
        end else if (m_free) begin
            if (req_valid != '0) begin
                m_found = 1'b0;
                for (int k = 1; k <= NUM_CH; k++) begin
                    m_c = (m_ptr + k) % NUM_CH;
                    if (!m_found && req_valid[m_c]) begin
                        m_found = 1'b1;
                        m_gid   = m_c;
                    end
                end
                m_ptr     = m_gid;
                exp_start = 1'b1;
                m_free    = 1'b0;
                m_skip    = 1'b1;
                m_left    = TOTAL;
            end
        end else if (m_skip) begin
            m_skip = 1'b0;
        end else if (s_tick) begin
            m_left--;
            if (m_left == 0) begin
                exp_done = 1'b1;
                m_free   = 1'b1;
            end
        end
        exp_busy = !m_free;
    end

    // Directed scenarios followed by randomized traffic
    initial begin
        int n;
        reset     = 1'b1;
        s_tick    = 1'b0;
        req_valid = '0;
        req_data  = '0;
        repeat (2) applyStimulus(1'b1);
        mon_en = 1'b1;

        $display("[TB] single byte on ch0");
        src_q[0].push_back(8'hA5);
        runIdle(1000);

        $display("[TB] all channels at once after reset");
        applyStimulus(1'b1);
        src_q[0].push_back(8'h10);
        src_q[1].push_back(8'h21);
        src_q[2].push_back(8'h32);
        src_q[3].push_back(8'h43);
        runIdle(4000);

        $display("[TB] wrap from ch2 to ch0");
        src_q[2].push_back(8'h77);
        runIdle(1000);
        src_q[2].push_back(8'h78);
        src_q[0].push_back(8'h79);
        runIdle(2000);

        $display("[TB] reset in the middle of a frame");
        src_q[3].push_back(8'hC3);
        n = 0;
        while (m_free && n < 10) begin
            applyStimulus(1'b0);
            n++;
        end
        repeat (80) applyStimulus(1'b0);
        repeat (2) applyStimulus(1'b1);
        src_q[1].push_back(8'h5A);
        src_q[0].push_back(8'h3C);
        runIdle(2000);

        $display("[TB] randomized traffic");
        tick_every  = 1'b0;
        present_pct = 30;
        for (int i = 0; i < 40; i++) begin
            src_q[$urandom_range(NUM_CH - 1)].push_back(8'($urandom_range(255)));
        end
        runIdle(40000);

        for (int ch = 0; ch < NUM_CH; ch++) begin
            checkOutput("leftover_bytes", 32'(exp_q[ch].size()), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between NUM_CH byte-stream requesters using round-robin arbitration.
- Captures one byte from the winning channel and issues a single-cycle tx_start with the byte on tx_din.
- Times the frame by counting baud ticks, then releases the transmitter for the next grant.
- Sits between the host-side byte sources and the UART transmitter, sharing the transmitter's s_tick baud strobe.

Parameters:
- NUM_CH, 4, number of requesting channels (2..8).
- BITWIDTH, 8, data bits per frame.
- SB_TICK, 16, s_tick pulses per bit period.
- GAP_TICKS, 16, idle s_tick pulses inserted after each frame before the next grant (0 allowed).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- s_tick  input  1  baud oversample strobe, one clk cycle wide.
- req_valid  input  NUM_CH  per-channel byte available; held until acknowledged.
- req_data  input  NUM_CH*BITWIDTH  channel i byte at bits [i*BITWIDTH +: BITWIDTH].
- req_ready  output  NUM_CH  one-hot, one-cycle acknowledge: byte captured.
- tx_start  output  1  one-cycle start pulse to the transmitter.
- tx_din  output  BITWIDTH  byte to transmit; stable from tx_start until the frame ends.
- busy  output  1  high in every state except IDLE.
- grant_id  output  clog2(NUM_CH), min 1  index of the last granted channel.
- frame_done  output  1  one-cycle pulse when frame plus gap timing completes.

Behaviour:
- Reset values: state IDLE; req_ready 0; tx_start 0; tx_din 0; busy 0; frame_done 0; grant_id 0; tick counter 0; round-robin pointer NUM_CH-1, so channel 0 has first priority.
- Reset asserted mid-frame aborts immediately. No frame_done is issued and no req_ready is pending afterwards.
- FRAME_TICKS = SB_TICK*(BITWIDTH+2), covering the start bit, data bits and one stop bit.
- TOTAL = FRAME_TICKS + GAP_TICKS. The tick counter is wide enough to hold TOTAL.
- IDLE:
  - If any req_valid is high at an edge, grant the first valid channel searching upward from pointer+1, wrapping modulo NUM_CH.
  - At that same edge: latch its req_data into tx_din, set grant_id and pointer to the winner, clear the counter, and go to START.
  - If no req_valid is high, stay in IDLE.
- START (exactly 1 cycle):
  - tx_start=1 and req_ready[grant]=1 in this cycle only. Go to WAIT.
  - Latency is one cycle: req_valid seen at edge n means tx_start and req_ready are high in cycle n+1.
- WAIT:
  - Each cycle with s_tick=1 increments the counter. Cycles without s_tick hold it.
  - An s_tick arriving in the START cycle is not counted.
  - On the edge where s_tick=1 and counter==TOTAL-1: frame_done=1 for the next cycle, return to IDLE, clear the counter.
- frame_done and a new grant cannot overlap. After frame_done, arbitration occurs at the next edge at the earliest, so there is at least one IDLE cycle between frames.
- Requester rule: hold req_valid and req_data stable until req_ready is seen. Drop req_valid, or present the next byte, in the cycle after req_ready.
- A channel that deasserts req_valid before being granted is simply skipped. No error is raised.
- Only a grant advances the pointer. A channel that is not requesting never holds priority.
- tx_din holds its value after the frame until the next grant.
- Simultaneous requests from all channels are served in strict rotation: i, i+1, … wrapping.
- NUM_CH=1 degenerates to a pass-through sequencer with grant_id always 0.

Optional Feature:
- Macro: UART_ARB_LOCK_EN.
- Enabled:
  - Extra input port req_lock, width NUM_CH.
  - If req_lock[grant_id] and req_valid[grant_id] are both high in the IDLE cycle following frame_done, the same channel is re-granted regardless of rotation. This keeps multi-byte packets contiguous.
  - The pointer stays on the locked channel.
  - A lock held for more than 255 consecutive frames is forcibly broken for one arbitration, so other channels are not starved.
- Disabled: the port is absent and arbitration is pure round-robin.

Test Plan:
- Reset, then req_valid=4'b0001 with req_data[7:0]=8'hA5 → tx_start and req_ready[0] in the cycle after; tx_din=8'hA5; frame_done after exactly 176 s_ticks (160+16); busy low afterwards.
- All four channels valid with data 8'h10/8'h21/8'h32/8'h43 → grants in order 0,1,2,3; tx_din sequence 10,21,32,43; four frame_done pulses; no req_ready overlap.
- Ch2 served, then ch2 and ch0 valid → ch0 granted next (wrap), then ch2.
- Reset asserted at tick 80 of a frame → next cycle busy=0, tx_start=0, pointer=3; a fresh request on ch1 is granted normally.
- GAP_TICKS=0 with s_tick every clock → frame_done exactly 160 s_ticks after START; an s_tick in the START cycle is not counted.
- With UART_ARB_LOCK_EN: ch1 locked with 3 bytes while ch0 and ch3 are also valid → ch1 is granted three times back-to-back, then ch3, then ch0.
